// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Decodes a MIPS instruction into the ALU operation, its two operands and a
// writeback tag, and hands the result to the EX stage through a two-entry
// valid/ready buffer: an output register plus one skid register. Because the
// skid register absorbs the entry that arrives in the cycle EX stalls,
// id_ready can be a flop output with no combinational path from ex_ready.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   id_valid / id_ready    upstream handshake (id_ready = skid empty)
//   instr, rs_data,        raw instruction word and the already-forwarded
//   rt_data                register operands
//   flush                  drop every held entry and the incoming one
//   ex_valid / ex_ready    downstream handshake
//   ALUop                  ALU operation code (ALU_OP_* localparams below)
//   ALUopnd1, ALUopnd2     ALU operands
//   ex_wreg, ex_wdst       GPR write enable and destination index
//   ex_illegal             unsupported opcode/funct
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [DW-1:0] instr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic          flush,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [3:0]    ALUop,
    output logic [DW-1:0] ALUopnd1,
    output logic [DW-1:0] ALUopnd2,
    output logic          ex_wreg,
    output logic [4:0]    ex_wdst,
    output logic          ex_illegal
);

    // ALU operation codes shared with the ALU
    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_AND  = 4'd2;
    localparam logic [3:0] ALU_OP_OR   = 4'd3;
    localparam logic [3:0] ALU_OP_XOR  = 4'd4;
    localparam logic [3:0] ALU_OP_NOR  = 4'd5;
    localparam logic [3:0] ALU_OP_SLT  = 4'd6;
    localparam logic [3:0] ALU_OP_SLTU = 4'd7;
    localparam logic [3:0] ALU_OP_SLL  = 4'd8;
    localparam logic [3:0] ALU_OP_SRL  = 4'd9;
    localparam logic [3:0] ALU_OP_SRA  = 4'd10;

    // One buffered entry: everything EX needs from this stage
    typedef struct packed {
        logic [3:0]    op;
        logic [DW-1:0] opnd1;
        logic [DW-1:0] opnd2;
        logic          wreg;
        logic [4:0]    wdst;
        logic          illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Instruction decode
    // -----------------------------------------------------------------------
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [4:0]    rt_idx;
    logic [4:0]    rd_idx;
    logic [4:0]    shamt;
    logic [DW-1:0] imm_sext;
    logic [DW-1:0] imm_zext;
    logic [DW-1:0] shamt_zext;

    assign opcode     = instr[31:26];
    assign funct      = instr[5:0];
    assign rt_idx     = instr[20:16];
    assign rd_idx     = instr[15:11];
    assign shamt      = instr[10:6];
    assign imm_sext   = {{(DW-16){instr[15]}}, instr[15:0]};
    assign imm_zext   = {{(DW-16){1'b0}}, instr[15:0]};
    assign shamt_zext = {{(DW-5){1'b0}}, shamt};

    // The rs field is not needed: rs_data arrives already read and forwarded.
    logic unused_rs_field;
    assign unused_rs_field = ^instr[25:21];

    entry_t     dec;
    logic       dec_legal;
    logic [3:0] dec_op;
    logic [DW-1:0] dec_opnd1;
    logic [DW-1:0] dec_opnd2;
    logic [4:0] dec_dst;

    always_comb begin
        dec_legal = 1'b1;
        dec_op    = ALU_OP_ADD;
        dec_opnd1 = rs_data;
        dec_opnd2 = rt_data;
        dec_dst   = 5'd0;

        if (opcode == 6'h00) begin
            // R-type: destination is rd
            dec_dst = rd_idx;
            unique case (funct)
                6'h20, 6'h21: dec_op = ALU_OP_ADD;
                6'h22, 6'h23: dec_op = ALU_OP_SUB;
                6'h24:        dec_op = ALU_OP_AND;
                6'h25:        dec_op = ALU_OP_OR;
                6'h26:        dec_op = ALU_OP_XOR;
                6'h27:        dec_op = ALU_OP_NOR;
                6'h2A:        dec_op = ALU_OP_SLT;
                6'h2B:        dec_op = ALU_OP_SLTU;
                // Shift by immediate: the shift amount travels in opnd1
                6'h00: begin
                    dec_op    = ALU_OP_SLL;
                    dec_opnd1 = shamt_zext;
                end
                6'h02: begin
                    dec_op    = ALU_OP_SRL;
                    dec_opnd1 = shamt_zext;
                end
                6'h03: begin
                    dec_op    = ALU_OP_SRA;
                    dec_opnd1 = shamt_zext;
                end
                // Variable shifts: ALU takes the amount from rs_data[4:0]
                6'h04:        dec_op = ALU_OP_SLL;
                6'h06:        dec_op = ALU_OP_SRL;
                6'h07:        dec_op = ALU_OP_SRA;
                default:      dec_legal = 1'b0;
            endcase
        end else begin
            // I-type: destination is rt, second operand is the immediate
            dec_dst = rt_idx;
            unique case (opcode)
                6'h08, 6'h09: begin
                    dec_op    = ALU_OP_ADD;
                    dec_opnd2 = imm_sext;
                end
                6'h0A: begin
                    dec_op    = ALU_OP_SLT;
                    dec_opnd2 = imm_sext;
                end
                6'h0B: begin
                    dec_op    = ALU_OP_SLTU;
                    dec_opnd2 = imm_sext;
                end
                6'h0C: begin
                    dec_op    = ALU_OP_AND;
                    dec_opnd2 = imm_zext;
                end
                6'h0D: begin
                    dec_op    = ALU_OP_OR;
                    dec_opnd2 = imm_zext;
                end
                6'h0E: begin
                    dec_op    = ALU_OP_XOR;
                    dec_opnd2 = imm_zext;
                end
                // LUI is executed as imm << 16 on the shifter
                6'h0F: begin
                    dec_op    = ALU_OP_SLL;
                    dec_opnd1 = DW'(16);
                    dec_opnd2 = imm_zext;
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        dec = '0;
        if (dec_legal) begin
            dec.op      = dec_op;
            dec.opnd1   = dec_opnd1;
            dec.opnd2   = dec_opnd2;
            dec.wdst    = dec_dst;
            // Writes to $0 are suppressed at the source
            dec.wreg    = (dec_dst != 5'd0);
            dec.illegal = 1'b0;
        end else begin
            // Illegal instructions travel as an inert ADD 0,0 with no write
            dec.op      = ALU_OP_ADD;
            dec.illegal = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Two-entry buffer: output register + skid register
    // -----------------------------------------------------------------------
    state_t state_q,    state_d;
    entry_t out_q,      out_d;
    entry_t skid_q,     skid_d;
    logic   id_ready_q, id_ready_d;
    logic   accept;

    assign accept = id_valid & id_ready_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    out_d   = dec;
                end
            end
            ST_ONE: begin
                if (accept && ex_ready) begin
                    // Head leaves as the new entry replaces it
                    out_d = dec;
                end else if (accept) begin
                    // EX stalled: park the new entry behind the head
                    state_d = ST_FULL;
                    skid_d  = dec;
                end else if (ex_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // id_ready is low here, so nothing new can arrive
                if (ex_ready) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Redirect wins over any handshake; payload contents become don't-care
        if (flush) begin
            state_d = ST_EMPTY;
        end

        // Registered ready: low exactly while the skid register is occupied
        id_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            id_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            id_ready_q <= id_ready_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign id_ready   = id_ready_q;
    assign ex_valid   = (state_q != ST_EMPTY);
    assign ALUop      = out_q.op;
    assign ALUopnd1   = out_q.opnd1;
    assign ALUopnd2   = out_q.opnd2;
    assign ex_wreg    = out_q.wreg;
    assign ex_wdst    = out_q.wdst;
    assign ex_illegal = out_q.illegal;

endmodule
